// File: rtl/anim_pkg.sv
// Shared types and constants for the animation scheduler slice.
// Pure definitions; no latency or backpressure of its own.
package anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    localparam logic [1:0] ANIM_IDLE  = 2'd0;
    localparam logic [1:0] ANIM_HAPPY = 2'd1;
    localparam logic [1:0] ANIM_EAT   = 2'd2;
    localparam logic [1:0] ANIM_SLEEP = 2'd3;

    localparam logic [15:0] COLOR_DEFAULT = 16'h2935;

    localparam int LCD_W_DEF = 132;
    localparam int LCD_H_DEF = 162;

    // Highest animation id wins.
    function automatic logic [1:0] pick_winner(input logic [2:0] p);
        if (p[2]) return ANIM_SLEEP;
        if (p[1]) return ANIM_EAT;
        if (p[0]) return ANIM_HAPPY;
        return ANIM_IDLE;
    endfunction

    function automatic logic [2:0] anim_bit(input logic [1:0] id);
        case (id)
            ANIM_HAPPY: return 3'b001;
            ANIM_EAT:   return 3'b010;
            ANIM_SLEEP: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/lcd_frame_tracker.sv
// Flags the first (0,0) fetch of each LCD frame; frame_start is combinational, same cycle.
// No backpressure: follows the LCD driver's address stream, ignoring off-panel addresses.
module lcd_frame_tracker #(
    parameter int LCD_W = anim_pkg::LCD_W_DEF,
    parameter int LCD_H = anim_pkg::LCD_H_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_addr_x,
    input  logic [7:0] lcd_addr_y,
    output logic       frame_start
);

    localparam logic [8:0] X_LIM = 9'(LCD_W);
    localparam logic [8:0] Y_LIM = 9'(LCD_H);

    logic [7:0] prev_x;
    logic [7:0] prev_y;
    logic       in_range;
    logic       at_origin;

    assign in_range    = ({1'b0, lcd_addr_x} < X_LIM) && ({1'b0, lcd_addr_y} < Y_LIM);
    assign at_origin   = (lcd_addr_x == 8'd0) && (lcd_addr_y == 8'd0);
    assign frame_start = at_origin && ((prev_x != 8'd0) || (prev_y != 8'd0));

    // Off-panel addresses are not remembered, so they can neither start nor suppress a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_x <= 8'd0;
            prev_y <= 8'd0;
        end else if (in_range) begin
            prev_x <= lcd_addr_x;
            prev_y <= lcd_addr_y;
        end
    end

endmodule

// File: rtl/anim_scheduler.sv
// Queues animation requests and switches the displayed source only at frame boundaries.
// pix_data is a zero-latency mux; requests are edge-latched, so no backpressure is needed.
module anim_scheduler #(
    parameter int LCD_W       = anim_pkg::LCD_W_DEF,
    parameter int LCD_H       = anim_pkg::LCD_H_DEF,
    parameter int PLAY_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [7:0]  lcd_addr_x,
    input  logic [7:0]  lcd_addr_y,
    input  logic [15:0] src_data0,
    input  logic [15:0] src_data1,
    input  logic [15:0] src_data2,
    input  logic [15:0] src_data3,
    output logic [15:0] pix_data,
    output logic [1:0]  anim_sel,
    output logic [7:0]  frame_idx,
    output logic        busy
);

    import anim_pkg::*;

    localparam logic [7:0] LAST_FRAME = 8'(PLAY_FRAMES - 1);

    state_t     state;
    logic [2:0] pending;
    logic [2:0] req_hist;
    logic [2:0] req_edge;
    logic [2:0] clr_bit;
    logic [1:0] winner;
    logic       frame_start;
    logic       last_frame;
    logic       take;

    lcd_frame_tracker #(
        .LCD_W (LCD_W),
        .LCD_H (LCD_H)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .lcd_addr_x  (lcd_addr_x),
        .lcd_addr_y  (lcd_addr_y),
        .frame_start (frame_start)
    );

    assign req_edge   = req & ~req_hist;
    assign winner     = pick_winner(pending);
    assign last_frame = (frame_idx == LAST_FRAME);

    always_comb begin
        take = 1'b0;
        case (state)
            ST_ARMED: take = frame_start;
            ST_PLAY:  take = frame_start && last_frame && (pending != 3'b000);
            default:  take = 1'b0;
        endcase
    end

    assign clr_bit = take ? anim_bit(winner) : 3'b000;

    // A fresh edge is OR-ed in after the clear, so a re-request of the winner survives as a replay.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pending   <= 3'b000;
            req_hist  <= 3'b000;
            anim_sel  <= ANIM_IDLE;
            frame_idx <= 8'd0;
        end else begin
            req_hist <= req;
            pending  <= (pending & ~clr_bit) | req_edge;
            case (state)
                ST_IDLE: begin
                    if (pending != 3'b000) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (frame_start) begin
                        state     <= ST_PLAY;
                        anim_sel  <= winner;
                        frame_idx <= 8'd0;
                    end
                end
                ST_PLAY: begin
                    if (frame_start) begin
                        if (!last_frame) begin
                            frame_idx <= frame_idx + 8'd1;
                        end else if (pending != 3'b000) begin
                            anim_sel  <= winner;
                            frame_idx <= 8'd0;
                        end else begin
                            state     <= ST_IDLE;
                            anim_sel  <= ANIM_IDLE;
                            frame_idx <= 8'd0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_PLAY);

    always_comb begin
        pix_data = COLOR_DEFAULT;
        case (anim_sel)
            2'd0:    pix_data = src_data0;
            2'd1:    pix_data = src_data1;
            2'd2:    pix_data = src_data2;
            2'd3:    pix_data = src_data3;
            default: pix_data = COLOR_DEFAULT;
        endcase
    end

endmodule

// File: tb/tb_anim_scheduler.sv
// Directed bench for anim_scheduler on a 4x3 panel, 2 frames per animation, 12-cycle sweeps.
// Each frame check compares {anim_sel, frame_idx, busy, pix_data} against hand-derived values.
module tb_anim_scheduler;

    localparam logic [15:0] SRC0 = 16'hA000;
    localparam logic [15:0] SRC1 = 16'hB001;
    localparam logic [15:0] SRC2 = 16'hC002;
    localparam logic [15:0] SRC3 = 16'hD003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [7:0]  lcd_addr_x = 8'd0;
    logic [7:0]  lcd_addr_y = 8'd0;
    logic [15:0] src_data0 = SRC0;
    logic [15:0] src_data1 = SRC1;
    logic [15:0] src_data2 = SRC2;
    logic [15:0] src_data3 = SRC3;
    logic [15:0] pix_data;
    logic [1:0]  anim_sel;
    logic [7:0]  frame_idx;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tears = 0;
    logic [1:0]  last_sel = 2'd0;
    logic [26:0] got;

    anim_scheduler #(
        .LCD_W       (4),
        .LCD_H       (3),
        .PLAY_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lcd_addr_x (lcd_addr_x),
        .lcd_addr_y (lcd_addr_y),
        .src_data0  (src_data0),
        .src_data1  (src_data1),
        .src_data2  (src_data2),
        .src_data3  (src_data3),
        .pix_data   (pix_data),
        .anim_sel   (anim_sel),
        .frame_idx  (frame_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Expected {anim_sel, frame_idx, busy, pix_data}; only animation 0 is non-busy.
    function automatic logic [26:0] exp_st(input logic [1:0] s, input logic [7:0] k);
        logic [15:0] p;
        case (s)
            2'd0:    p = SRC0;
            2'd1:    p = SRC1;
            2'd2:    p = SRC2;
            default: p = SRC3;
        endcase
        return {s, k, (s != 2'd0), p};
    endfunction

    // One full raster sweep; req = pv on cycles [p_from, p_to), rst high on cycle rst_idx.
    task automatic run_frame(input logic [2:0] pv, input int p_from, input int p_to, input int rst_idx);
        for (int i = 0; i < 12; i++) begin
            lcd_addr_x = 8'(i % 4);
            lcd_addr_y = 8'(i / 4);
            req        = (i >= p_from && i < p_to) ? pv : 3'b000;
            rst        = (i == rst_idx);
            @(posedge clk);
            #1;
            if (anim_sel !== last_sel && i != 0 && i != rst_idx) tears++;
            last_sel = anim_sel;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b000;
        lcd_addr_x = 8'd0;
        lcd_addr_y = 8'd0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        got = {anim_sel, frame_idx, busy, pix_data};
        n_cmp++;
        if (got !== exp_st(2'd0, 8'd0)) begin
            n_bad++;
            $display("FAIL reset_state: got {sel,idx,busy,pix}=%h want %h", got, exp_st(2'd0, 8'd0));
        end
        last_sel = anim_sel;
        rst = 1'b0;
        for (int f = 0; f < 3; f++) begin
            run_frame(3'b000, 0, 0, -1);
            got = {anim_sel, frame_idx, busy, pix_data};
            n_cmp++;
            if (got !== exp_st(2'd0, 8'd0)) begin
                n_bad++;
                $display("FAIL reset_idle f%0d: got %h want %h", f, got, exp_st(2'd0, 8'd0));
            end
        end
    endtask

    task automatic test_single();
        logic [26:0] want [4];
        want = '{exp_st(2'd0, 8'd0), exp_st(2'd1, 8'd0), exp_st(2'd1, 8'd1), exp_st(2'd0, 8'd0)};
        for (int f = 0; f < 4; f++) begin
            if (f == 0) run_frame(3'b001, 6, 7, -1);
            else        run_frame(3'b000, 0, 0, -1);
            got = {anim_sel, frame_idx, busy, pix_data};
            n_cmp++;
            if (got !== want[f]) begin
                n_bad++;
                $display("FAIL single f%0d: got %h want %h", f, got, want[f]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [26:0] want [6];
        want = '{exp_st(2'd0, 8'd0), exp_st(2'd2, 8'd0), exp_st(2'd2, 8'd1),
                 exp_st(2'd1, 8'd0), exp_st(2'd1, 8'd1), exp_st(2'd0, 8'd0)};
        tears = 0;
        for (int f = 0; f < 6; f++) begin
            if (f == 0) run_frame(3'b011, 6, 7, -1);
            else        run_frame(3'b000, 0, 0, -1);
            got = {anim_sel, frame_idx, busy, pix_data};
            n_cmp++;
            if (got !== want[f]) begin
                n_bad++;
                $display("FAIL back_to_back f%0d: got %h want %h", f, got, want[f]);
            end
        end
        n_cmp++;
        if (tears !== 0) begin
            n_bad++;
            $display("FAIL back_to_back_tear: got %0d mid-frame switches want 0", tears);
        end
    endtask

    task automatic test_no_preempt();
        logic [26:0] want [6];
        want = '{exp_st(2'd0, 8'd0), exp_st(2'd1, 8'd0), exp_st(2'd1, 8'd1),
                 exp_st(2'd3, 8'd0), exp_st(2'd3, 8'd1), exp_st(2'd0, 8'd0)};
        tears = 0;
        for (int f = 0; f < 6; f++) begin
            if (f == 0)      run_frame(3'b001, 6, 7, -1);
            else if (f == 1) run_frame(3'b100, 3, 4, -1);
            else             run_frame(3'b000, 0, 0, -1);
            got = {anim_sel, frame_idx, busy, pix_data};
            n_cmp++;
            if (got !== want[f]) begin
                n_bad++;
                $display("FAIL no_preempt f%0d: got %h want %h", f, got, want[f]);
            end
        end
        n_cmp++;
        if (tears !== 0) begin
            n_bad++;
            $display("FAIL no_preempt_tear: got %0d mid-frame switches want 0", tears);
        end
    endtask

    task automatic test_replay();
        logic [26:0] want [6];
        want = '{exp_st(2'd0, 8'd0), exp_st(2'd1, 8'd0), exp_st(2'd1, 8'd1),
                 exp_st(2'd1, 8'd0), exp_st(2'd1, 8'd1), exp_st(2'd0, 8'd0)};
        for (int f = 0; f < 6; f++) begin
            if (f == 0)      run_frame(3'b001, 6, 7, -1);
            else if (f == 1) run_frame(3'b001, 3, 4, -1);
            else             run_frame(3'b000, 0, 0, -1);
            got = {anim_sel, frame_idx, busy, pix_data};
            n_cmp++;
            if (got !== want[f]) begin
                n_bad++;
                $display("FAIL replay f%0d: got %h want %h", f, got, want[f]);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        logic [26:0] want [5];
        want = '{exp_st(2'd0, 8'd0), exp_st(2'd2, 8'd0), exp_st(2'd0, 8'd0),
                 exp_st(2'd0, 8'd0), exp_st(2'd0, 8'd0)};
        for (int f = 0; f < 5; f++) begin
            if (f == 0)      run_frame(3'b010, 6, 7, -1);
            else if (f == 1) run_frame(3'b010, 3, 4, -1);
            else if (f == 2) run_frame(3'b000, 0, 0, 6);
            else             run_frame(3'b000, 0, 0, -1);
            got = {anim_sel, frame_idx, busy, pix_data};
            n_cmp++;
            if (got !== want[f]) begin
                n_bad++;
                $display("FAIL reset_mid_play f%0d: got %h want %h", f, got, want[f]);
            end
        end
    endtask

    task automatic test_held_level();
        logic [26:0] want [6];
        want = '{exp_st(2'd0, 8'd0), exp_st(2'd1, 8'd0), exp_st(2'd1, 8'd1),
                 exp_st(2'd0, 8'd0), exp_st(2'd0, 8'd0), exp_st(2'd0, 8'd0)};
        for (int f = 0; f < 6; f++) begin
            if (f < 3)       run_frame(3'b001, 0, 12, -1);
            else if (f == 3) run_frame(3'b001, 0, 4, -1);
            else             run_frame(3'b000, 0, 0, -1);
            got = {anim_sel, frame_idx, busy, pix_data};
            n_cmp++;
            if (got !== want[f]) begin
                n_bad++;
                $display("FAIL held_level f%0d: got %h want %h", f, got, want[f]);
            end
        end
    endtask

    task automatic test_held_through_reset();
        logic [26:0] want [4];
        want = '{exp_st(2'd0, 8'd0), exp_st(2'd3, 8'd0), exp_st(2'd3, 8'd1), exp_st(2'd0, 8'd0)};
        for (int f = 0; f < 4; f++) begin
            if (f == 0) run_frame(3'b100, 0, 12, 0);
            else        run_frame(3'b000, 0, 0, -1);
            got = {anim_sel, frame_idx, busy, pix_data};
            n_cmp++;
            if (got !== want[f]) begin
                n_bad++;
                $display("FAIL held_through_reset f%0d: got %h want %h", f, got, want[f]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_no_preempt();
        test_replay();
        test_reset_mid_play();
        test_held_level();
        test_held_through_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/anim_scheduler.md
ANIM_SCHEDULER -- requirements
Module: anim_scheduler

Interface
REQ-001 SHALL have parameter LCD_W, default 132, meaning panel width in pixels (x range 0..LCD_W-1).
REQ-002 SHALL have parameter LCD_H, default 162, meaning panel height in pixels (y range 0..LCD_H-1).
REQ-003 SHALL have parameter PLAY_FRAMES, default 8, meaning the number of full LCD frames one animation plays (range 1..255).
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  3  animation requests, level, one bit per animation: bit0=HAPPY(id1), bit1=EAT(id2), bit2=SLEEP(id3).
REQ-007 lcd_addr_x  input  8  pixel x address currently fetched by the LCD driver.
REQ-008 lcd_addr_y  input  8  pixel y address currently fetched by the LCD driver.
REQ-009 src_data0..src_data3  input  16 each  RGB565 pixel from animation 0 (IDLE) to animation 3.
REQ-010 pix_data  output  16  RGB565 pixel forwarded to the LCD driver.
REQ-011 anim_sel  output  2  id of the animation currently displayed.
REQ-012 frame_idx  output  8  frames completed in the current animation.
REQ-013 busy  output  1  high while a non-idle animation is displayed.

Function
REQ-014 Frame boundary: frame_start SHALL pulse for one cycle when (lcd_addr_x,lcd_addr_y) equals (0,0) and the registered previous address does not equal (0,0).
REQ-015 Request capture: a 0->1 edge on any req bit SHALL set the matching bit of a 3-bit pending register in the next cycle; a held-high level SHALL NOT set it again.
REQ-016 Arbitration: fixed priority, with the highest id winning (bit2 > bit1 > bit0); the winning pending bit SHALL be cleared in the same cycle its animation is selected.
REQ-017 FSM states: IDLE, ARMED, PLAY.
REQ-018 IDLE -> ARMED when pending != 0; anim_sel stays 0.
REQ-019 ARMED -> PLAY on frame_start; at that edge anim_sel := winner, frame_idx := 0, busy := 1.
REQ-020 PLAY: on each frame_start, frame_idx SHALL increment by 1; on the frame_start where frame_idx == PLAY_FRAMES-1, playback ends.
REQ-021 At end of playback: if pending != 0, the new winner SHALL be selected at that same frame_start, with frame_idx := 0 and the FSM staying in PLAY.
REQ-022 At end of playback with pending == 0: the FSM goes to IDLE, anim_sel := 0, frame_idx := 0, busy := 0.
REQ-023 Switching: anim_sel SHALL change only on a frame_start cycle, so the displayed image never tears mid-frame.
REQ-024 Requests arriving during ARMED or PLAY SHALL be latched and SHALL NOT preempt the running animation.
REQ-025 A request for the animation currently playing SHALL queue one replay.
REQ-026 A simultaneous req edge and winner clear on the same bit SHALL leave the bit set, because set wins.
REQ-027 pix_data SHALL be a combinational mux of src_data[anim_sel], with zero added latency.
REQ-028 An anim_sel value out of range (defensive default) SHALL output 16'h2935.
REQ-029 Addresses outside the panel range SHALL NOT generate frame_start and SHALL NOT alter state.

Reset
REQ-030 With rst high at a clock edge, the block SHALL enter IDLE with pending=0, anim_sel=0, frame_idx=0, busy=0, previous address=(0,0), and pix_data=src_data0.
REQ-031 Reset mid-PLAY SHALL discard all pending requests; the first frame after reset SHALL show IDLE.
REQ-032 The req edge detector SHALL reset its history to the current-low assumption (history=0), so a req held high through reset registers as one edge after reset.

Structure
REQ-033 A shared package anim_pkg SHALL hold the state enum (IDLE/ARMED/PLAY), animation ids (ANIM_IDLE=0, HAPPY=1, EAT=2, SLEEP=3), the default colour 16'h2935 and the LCD_W/LCD_H defaults.
REQ-034 One sub-module, lcd_frame_tracker, SHALL register the previous address and produce frame_start.
REQ-035 Arbitration, pending, FSM and mux SHALL reside in anim_scheduler.

Verification (bench: LCD_W=4, LCD_H=3, PLAY_FRAMES=2, address sweep 12 cycles/frame)
REQ-036 Reset with req=3'b000 -> anim_sel=0, busy=0, pix_data==src_data0 for 3 frames.
REQ-037 1-cycle pulse req=3'b001 at pixel (2,1) -> anim_sel=1 from the next (0,0), busy=1, frame_idx 0 then 1, back to 0/IDLE after 2 frames.
REQ-038 req=3'b011 pulsed together -> EAT(2) plays 2 frames, then HAPPY(1) plays 2 frames with no idle frame between, then IDLE.
REQ-039 Pulse req=3'b100 during HAPPY playback -> HAPPY completes both frames before SLEEP starts; anim_sel never changes at a non-(0,0) address.
REQ-040 rst asserted at frame_idx=1 with pending=3'b010 -> next frame shows IDLE, pending=0, busy=0.
REQ-041 req bit0 held high for 40 cycles -> exactly one HAPPY playback.
